// File: rtl/seg7_pkg.sv
// Shared helpers for the multiplexed 7-segment scanner.
//  - hex_to_seg : 4-bit nibble to segment pattern, bit order g..a (bit6..bit0)
//  - off_level  : inactive pin level for a given active-low setting
//  - *_bank_lsb : bit offset of one bank inside the flattened input buses
package seg7_pkg;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h00;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // An active-low pin is off when driven high, so the off level equals the flag.
    // The same value is also the XOR mask that converts logical to pin polarity.
    function automatic logic off_level(input bit act_lo);
        return act_lo;
    endfunction

    // di and dp: bank 0 occupies the low end of the bus.
    function automatic int di_bank_lsb(input int b, input int ndig);
        return b * ndig * 4;
    endfunction

    function automatic int dp_bank_lsb(input int b, input int ndig);
        return b * ndig;
    endfunction

    // pixels: bank 0 occupies the HIGH end of the bus (reverse bank order).
    function automatic int pix_bank_lsb(input int b, input int nbank, input int ndig);
        return (nbank - 1 - b) * ndig * 8;
    endfunction

endpackage

// File: rtl/seg7_bank_dec.sv
// Combinational segment decoder for one display bank.
//  nibbles : NDIG hex nibbles of this bank (snapshot), digit d at [d*4 +: 4]
//  pixels  : NDIG raw segment bytes of this bank (snapshot), digit d at [d*8 +: 8]
//  dp      : NDIG decimal points (hex mode only)
//  direct  : 1 selects raw pixels, 0 selects hex decode
//  lzb     : leading-zero blanking enable (hex mode only)
//  idx     : digit currently being scanned
//  seg     : logical (active-high) segments, bit7 = dp, bits 6..0 = g..a
module seg7_bank_dec
    import seg7_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NDIG*4-1:0] nibbles,
    input  logic [NDIG*8-1:0] pixels,
    input  logic [NDIG-1:0]   dp,
    input  logic              direct,
    input  logic              lzb,
    input  logic [IDX_W-1:0]  idx,
    output logic [7:0]        seg
);

    logic [3:0] nib;
    logic [7:0] pix;
    logic       dp_bit;
    logic       upper_nonzero;
    logic       blank;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        nib           = 4'h0;
        pix           = 8'h00;
        dp_bit        = 1'b0;
        upper_nonzero = 1'b0;
        for (int d = 0; d < NDIG; d++) begin
            if (IDX_W'(d) == idx) begin
                nib    = nibbles[d*4 +: 4];
                pix    = pixels[d*8 +: 8];
                dp_bit = dp[d];
            end
            // Any nonzero nibble at or above the scanned digit keeps it lit.
            if (d >= int'(idx) && nibbles[d*4 +: 4] != 4'h0) begin
                upper_nonzero = 1'b1;
            end
        end

        // Digit 0 is never blanked so an all-zero value still shows "0".
        blank = lzb && (idx != '0) && !upper_nonzero;

        if (direct) begin
            seg = pix;
        end else if (blank) begin
            seg = 8'h00;
        end else begin
            seg = {dp_bit, hex_to_seg(nib)};
        end
    end

endmodule

// File: rtl/seg7_nxm_scan.sv
// Multiplexed 7-segment driver: NBANK banks of NDIG digits scanned in lockstep.
//  clk    : system clock
//  reset  : asynchronous, active-low reset
//  di     : hex nibbles, bank b digit d = di[(b*NDIG+d)*4 +: 4]
//  pixels : raw segments, bank b digit d = pixels[((NBANK-1-b)*NDIG+d)*8 +: 8]
//  dp     : decimal points, indexed like di
//  direct : 1 = pixels drive segments, 0 = hex decode of di
//  lzb    : leading-zero blanking (hex mode only)
//  bright : PWM duty, 0 = dark, all-ones = full on (not snapshotted)
//  seg    : bank b = seg[b*8 +: 8], bit7 = dp, bits 6..0 = g..a
//  an     : bank b = an[b*NDIG +: NDIG], bit d selects digit d
//  frame  : one-clock pulse at each frame start
// All display inputs except bright are snapshotted once per frame so a
// CPU update never tears a frame.
module seg7_nxm_scan
    import seg7_pkg::*;
#(
    parameter int NBANK      = 2,
    parameter int NDIG       = 4,
    parameter int PRESC_W    = 16,
    parameter int PWM_W      = 4,
    parameter bit SEG_ACT_LO = 1'b1,
    parameter bit AN_ACT_LO  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NBANK*NDIG*4-1:0] di,
    input  logic [NBANK*NDIG*8-1:0] pixels,
    input  logic [NBANK*NDIG-1:0]   dp,
    input  logic                    direct,
    input  logic                    lzb,
    input  logic [PWM_W-1:0]        bright,
    output logic [NBANK*8-1:0]      seg,
    output logic [NBANK*NDIG-1:0]   an,
    output logic                    frame
);

    localparam int                    IDX_W    = $clog2(NDIG);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NDIG - 1);
    // The off pattern doubles as the polarity XOR mask.
    localparam logic [NBANK*8-1:0]    SEG_OFF  = {(NBANK*8){off_level(SEG_ACT_LO)}};
    localparam logic [NBANK*NDIG-1:0] AN_OFF   = {(NBANK*NDIG){off_level(AN_ACT_LO)}};

    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        idx;
    logic                    first_tick;
    logic                    tick;
    logic                    wrap;
    logic                    capture;

    logic [NBANK*NDIG*4-1:0] snap_di;
    logic [NBANK*NDIG*8-1:0] snap_pix;
    logic [NBANK*NDIG-1:0]   snap_dp;
    logic                    snap_direct;
    logic                    snap_lzb;

    logic [PWM_W-1:0]        pwm;
    logic                    slot_on;
    logic [NDIG-1:0]         digit_onehot;
    logic [NBANK*8-1:0]      seg_logic;
    logic [NBANK*NDIG-1:0]   an_logic;

    assign tick    = &presc;
    assign wrap    = tick && (idx == IDX_LAST);
    // The first tick after reset also captures, so fresh inputs appear
    // without waiting a whole frame.
    assign capture = tick && (wrap || first_tick);

    // Scan timing: prescaler and digit index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc      <= '0;
            idx        <= '0;
            first_tick <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            presc <= presc + PRESC_W'(1);
            if (tick) begin
                idx        <= wrap ? '0 : idx + IDX_W'(1);
                first_tick <= 1'b0;
            end
        end
    end

    // Frame snapshot of the display inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the wide snapshot registers are reset deliberately, so the
            // display shows a defined pattern before the first capture.
            snap_di     <= '0;
            snap_pix    <= '0;
            snap_dp     <= '0;
            snap_direct <= 1'b0;
            snap_lzb    <= 1'b0;
        end else if (capture) begin
            snap_di     <= di;
            snap_pix    <= pixels;
            snap_dp     <= dp;
            snap_direct <= direct;
            snap_lzb    <= lzb;
        end
    end

    // Brightness: compare the top prescaler bits against bright. The first
    // clock of every slot is dark so the previous digit cannot ghost.
    assign pwm          = presc[PRESC_W-1 -: PWM_W];
    assign slot_on      = ((&bright) || (pwm < bright)) && (presc != '0);
    assign digit_onehot = NDIG'(1) << idx;

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        seg7_bank_dec #(
            .NDIG  (NDIG),
            .IDX_W (IDX_W)
        ) u_dec (
            .nibbles (snap_di[di_bank_lsb(b, NDIG) +: NDIG*4]),
            .pixels  (snap_pix[pix_bank_lsb(b, NBANK, NDIG) +: NDIG*8]),
            .dp      (snap_dp[dp_bank_lsb(b, NDIG) +: NDIG]),
            .direct  (snap_direct),
            .lzb     (snap_lzb),
            .idx     (idx),
            .seg     (seg_logic[b*8 +: 8])
        );

        assign an_logic[b*NDIG +: NDIG] = slot_on ? digit_onehot : '0;
    end

    // Registered pin drivers with polarity applied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg   <= SEG_OFF;
            an    <= AN_OFF;
            frame <= 1'b0;
        end else begin
            seg   <= seg_logic ^ SEG_OFF;
            an    <= an_logic ^ AN_OFF;
            frame <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_nxm_scan.sv
// Self-checking bench for seg7_nxm_scan (PRESC_W=3, PWM_W=2, active-low pins).
// A second instance with NBANK=1, NDIG=3 exercises the non-power-of-2 wrap.
module tb_seg7_nxm_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] di;
    logic [63:0] pixels;
    logic [7:0]  dp;
    logic        direct;
    logic        lzb;
    logic [1:0]  bright;
    logic [15:0] seg;
    logic [7:0]  an;
    logic        frame;

    logic [11:0] di3;
    logic [23:0] pixels3;
    logic [2:0]  dp3;
    logic        direct3;
    logic        lzb3;
    logic [1:0]  bright3;
    logic [7:0]  seg3;
    logic [2:0]  an3;
    logic        frame3;

    assign di3     = 12'h210;
    assign pixels3 = 24'h0;
    assign dp3     = 3'b100;
    assign direct3 = 1'b0;
    assign lzb3    = 1'b0;
    assign bright3 = 2'b11;

    always #5 clk = ~clk;

    seg7_nxm_scan #(
        .NBANK(2), .NDIG(4), .PRESC_W(3), .PWM_W(2), .SEG_ACT_LO(1'b1), .AN_ACT_LO(1'b1)
    ) u_dut (
        .clk(clk), .reset(reset), .di(di), .pixels(pixels), .dp(dp), .direct(direct),
        .lzb(lzb), .bright(bright), .seg(seg), .an(an), .frame(frame)
    );

    seg7_nxm_scan #(
        .NBANK(1), .NDIG(3), .PRESC_W(3), .PWM_W(2), .SEG_ACT_LO(1'b1), .AN_ACT_LO(1'b1)
    ) u_dut3 (
        .clk(clk), .reset(reset), .di(di3), .pixels(pixels3), .dp(dp3), .direct(direct3),
        .lzb(lzb3), .bright(bright3), .seg(seg3), .an(an3), .frame(frame3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: clocks since reset release and the frame snapshot.
    int          cyc;
    logic [31:0] m_di;
    logic [63:0] m_pix;
    logic [7:0]  m_dp;
    logic        m_direct;
    logic        m_lzb;
    bit          m3_valid;

    logic [15:0] obs_seg;
    logic [7:0]  obs_an;
    logic        obs_frame;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [31:0] di;
        logic [63:0] pix;
        logic [7:0]  dp;
        logic        direct;
        logic        lzb;
        logic [63:0] exp;   // logical byte for bank b digit d at [(b*4+d)*8 +: 8]
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Logical segment byte of digit d of one bank, straight from the display rules.
    function automatic logic [7:0] ref_seg(input logic [63:0] bank_val, input logic [7:0] pix,
                                           input logic dpb, input logic dir, input logic lz,
                                           input int d);
        logic [3:0] nib;
        nib = 4'(bank_val >> (4 * d));
        if (dir) return pix;
        if (lz && d > 0 && (bank_val >> (4 * d)) == 64'h0) return 8'h00;
        return {dpb, HEX[nib]};
    endfunction

    // One clock: predict the outputs produced by the current scan position,
    // advance the model, then compare on the falling edge.
    task automatic step();
        int          presc, idx, idx3;
        bit          on, on3;
        logic [15:0] e_seg;
        logic [7:0]  e_an;
        logic        e_frame;
        logic [7:0]  e_seg3;
        logic [2:0]  e_an3;
        logic        e_frame3;
        logic [15:0] bank;
        presc = cyc % 8;
        idx   = (cyc / 8) % 4;
        idx3  = (cyc / 8) % 3;
        on    = (presc != 0) && (bright == 2'd3 || (presc / 2) < int'(bright));
        on3   = (presc != 0);
        for (int b = 0; b < 2; b++) begin
            bank = 16'(m_di >> (16 * b));
            e_seg[b*8 +: 8] = ref_seg({48'h0, bank}, 8'(m_pix >> (((1 - b) * 4 + idx) * 8)),
                                      m_dp[b*4 + idx], m_direct, m_lzb, idx) ^ 8'hFF;
            e_an[b*4 +: 4]  = on ? ~(4'b0001 << idx) : 4'hF;
        end
        e_frame  = (presc == 7) && (idx == 3);
        if (m3_valid) e_seg3 = ref_seg({52'h0, di3}, 8'h00, dp3[idx3], 1'b0, 1'b0, idx3) ^ 8'hFF;
        else          e_seg3 = ref_seg(64'h0, 8'h00, 1'b0, 1'b0, 1'b0, idx3) ^ 8'hFF;
        e_an3    = on3 ? ~(3'b001 << idx3) : 3'h7;
        e_frame3 = (presc == 7) && (idx3 == 2);

        if (presc == 7 && (cyc == 7 || idx == 3)) begin
            m_di     = di;
            m_pix    = pixels;
            m_dp     = dp;
            m_direct = direct;
            m_lzb    = lzb;
        end
        if (presc == 7 && (cyc == 7 || idx3 == 2)) m3_valid = 1'b1;

        @(posedge clk);
        cyc++;
        @(negedge clk);
        check("scan", {39'h0, frame, an, seg}, {39'h0, e_frame, e_an, e_seg});
        check("scan3", {52'h0, frame3, an3, seg3}, {52'h0, e_frame3, e_an3, e_seg3});
        obs_seg   = seg;
        obs_an    = an;
        obs_frame = frame;
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 100; i++) begin
            step();
            if (obs_frame) return;
        end
        check("frame_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {39'h0, frame, an, seg}, {39'h0, 1'b0, 8'hFF, 16'hFFFF});
        check({tag, "3"}, {52'h0, frame3, an3, seg3}, {52'h0, 1'b0, 3'h7, 8'hFF});
    endtask

    task automatic model_reset();
        cyc      = 0;
        m_di     = '0;
        m_pix    = '0;
        m_dp     = '0;
        m_direct = 1'b0;
        m_lzb    = 1'b0;
        m3_valid = 1'b0;
    endtask

    initial begin
        int pwm_exp [4];
        int cnt;

        vecs[0] = '{32'h0000_12AF, 64'h0, 8'h00, 1'b0, 1'b0, 64'h3F3F3F3F_065B7771};
        vecs[1] = '{32'h8765_4321, 64'h0, 8'h21, 1'b0, 1'b0, 64'h7F07FD6D_664F5B86};
        vecs[2] = '{32'h0000_0030, 64'h0, 8'hFF, 1'b0, 1'b1, 64'h000000BF_0000CFBF};
        vecs[3] = '{32'h0000_0000, 64'h8142_2418_0102_0408, 8'hFF, 1'b1, 1'b1,
                    64'h01020408_81422418};
        vecs[4] = '{32'h000C_0B00, 64'h0, 8'h00, 1'b0, 1'b1, 64'h00000039_007C3F3F};
        pwm_exp = '{0, 4, 12, 28};

        reset  = 1'b0;
        di     = '0;
        pixels = '0;
        dp     = '0;
        direct = 1'b0;
        lzb    = 1'b0;
        bright = 2'd3;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_init");
        reset = 1'b1;

        // Table vectors: one full frame per record, sampled mid-slot.
        foreach (vecs[i]) begin
            di     = vecs[i].di;
            pixels = vecs[i].pix;
            dp     = vecs[i].dp;
            direct = vecs[i].direct;
            lzb    = vecs[i].lzb;
            bright = 2'd3;
            wait_frame();
            for (int j = 1; j <= 32; j++) begin
                step();
                if ((j - 1) % 8 == 4) begin
                    int d;
                    d = (j - 1) / 8;
                    check($sformatf("vec%0d_seg_d%0d", i, d), {48'h0, obs_seg},
                          {48'h0, ~vecs[i].exp[(4 + d)*8 +: 8], ~vecs[i].exp[d*8 +: 8]});
                    check($sformatf("vec%0d_an_d%0d", i, d), {56'h0, obs_an},
                          {56'h0, ~(4'(1) << d), ~(4'(1) << d)});
                end
            end
        end

        // Tearing: a mid-frame change must not show until the next frame.
        direct = 1'b0;
        lzb    = 1'b0;
        dp     = 8'h00;
        di     = 32'h0000_1234;
        wait_frame();
        repeat (12) step();
        di = 32'h0000_5678;
        repeat (9) step();
        check("tear_old", {56'h0, obs_seg[7:0]}, {56'h0, ~8'h5B});
        wait_frame();
        repeat (5) step();
        check("tear_new", {56'h0, obs_seg[7:0]}, {56'h0, ~8'h7F});

        // Brightness: active anode clocks per frame in bank 0.
        for (int b = 0; b < 4; b++) begin
            bright = 2'(b);
            wait_frame();
            cnt = 0;
            repeat (32) begin
                step();
                if (obs_an[3:0] != 4'hF) cnt++;
            end
            check($sformatf("pwm_bright%0d", b), 64'(cnt), 64'(pwm_exp[b]));
        end

        // Randomised traffic against the model.
        for (int r = 0; r < 30; r++) begin
            di[31:16] = 16'($urandom) >> (4 * $urandom_range(0, 4));
            di[15:0]  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            pixels    = {$urandom, $urandom};
            dp        = 8'($urandom);
            direct    = ($urandom_range(0, 3) == 0);
            lzb       = 1'($urandom_range(0, 1));
            bright    = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 40)) step();
        end

        // Reset mid-scan: outputs go inactive without waiting for a clock.
        repeat (11) step();
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_hold");
        model_reset();
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            cnt++;
            if (obs_frame) break;
        end
        check("restart_frame_delay", 64'(cnt), 64'd32);
        repeat (40) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
